pattern_memcpy_engine: RTL and testbench

//  Copy engine directly downstream of the action register slave: consumes pattern_memcpy_enable,

---
 rtl/memcpy_pkg.sv | 28 ++
 rtl/memcpy_burst_buf.sv | 28 ++
 rtl/pattern_memcpy_engine.sv | 198 +++++++++++++++++++
 tb/tb_pattern_memcpy_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memcpy_pkg.sv
// Shared types and constants for the pattern memcpy engine.
package memcpy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_DONE
  } state_t;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam int unsigned PAGE_BYTES    = 4096;

  // bytes per data beat
  function automatic int bpb_of(input int dw);
    return dw / 8;
  endfunction

  // shift that converts bytes to beats
  function automatic int bpb_log2(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/memcpy_burst_buf.sv
// One-burst staging buffer: beat-indexed write port, registered read port.
module memcpy_burst_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 64,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // storage array, no reset needed
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // read register; cleared so the write data bus idles at zero
  always_ff @(posedge clk or posedge rst)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/pattern_memcpy_engine.sv
// AXI4 copy engine: read a burst into the local buffer, write it back out,
// repeat until the byte count is exhausted. Bursts never cross 4KB.
module pattern_memcpy_engine
  import memcpy_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_MAX  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pattern_memcpy_enable,
  input  logic [ADDR_WIDTH-1:0] pattern_source_address,
  input  logic [ADDR_WIDTH-1:0] pattern_target_address,
  input  logic [63:0]           pattern_total_number,
  output logic                  pattern_memcpy_done,
  output logic                  pattern_memcpy_error,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int LB = bpb_log2(DATA_WIDTH);
  localparam int IW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  state_t                state, state_nx;
  logic                  en_q, abort, error;
  logic [ADDR_WIDTH-1:0] src, tgt, step_b;
  logic [63:0]           beats_left, len_c;
  logic [7:0]            len_m1, rbeat, wbeat;
  logic [8:0]            len;
  logic [12:0]           src_room, tgt_room;
  logic                  start, r_fire, r_end, w_fire, w_end, b_fire, stop;
  logic                  buf_re;
  logic [IW-1:0]         buf_raddr;

  assign start  = (state == S_IDLE) && pattern_memcpy_enable && !en_q;
  assign stop   = abort || !pattern_memcpy_enable;
  assign len    = {1'b0, len_m1} + 9'd1;
  assign step_b = ADDR_WIDTH'(len) << LB;

  assign r_fire = (state == S_RD_DATA) && m_axi_rvalid;
  assign r_end  = r_fire && (m_axi_rlast || (rbeat == len_m1));
  assign w_fire = (state == S_WR_DATA) && m_axi_wready;
  assign w_end  = w_fire && (wbeat == len_m1);
  assign b_fire = (state == S_WR_RESP) && m_axi_bvalid;

  // beats left before each address reaches its next 4KB page
  assign src_room = (13'(PAGE_BYTES) - {1'b0, src[11:0]}) >> LB;
  assign tgt_room = (13'(PAGE_BYTES) - {1'b0, tgt[11:0]}) >> LB;

  // burst length = min(BURST_MAX, beats_left, src room, tgt room)
  always_comb begin
    len_c = 64'(BURST_MAX);
    if (beats_left < len_c)         len_c = beats_left;
    if (64'(src_room) < len_c)      len_c = 64'(src_room);
    if (64'(tgt_room) < len_c)      len_c = 64'(tgt_room);
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  // next state and handshake outputs
  always_comb begin
    state_nx      = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    pattern_memcpy_done = 1'b0;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_CALC;
      S_CALC: begin
        if (stop)                  state_nx = S_IDLE;
        else if (beats_left == '0) state_nx = S_DONE;
        else                       state_nx = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_axi_rready = 1'b1;
        if (r_end) state_nx = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = S_WR_DATA;
      end
      S_WR_DATA: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = (wbeat == len_m1);
        if (w_end) state_nx = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (stop)                          state_nx = S_IDLE;
          else if (beats_left != 64'(len))   state_nx = S_CALC;
          else                               state_nx = S_DONE;
        end
      end
      S_DONE: begin
        pattern_memcpy_done = 1'b1;
        if (!pattern_memcpy_enable) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // copy bookkeeping: addresses, remaining beats, beat counters, sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en_q       <= 1'b0;
      abort      <= 1'b0;
      error      <= 1'b0;
      src        <= '0;
      tgt        <= '0;
      beats_left <= '0;
      len_m1     <= '0;
      rbeat      <= '0;
      wbeat      <= '0;
    end else begin
      en_q <= pattern_memcpy_enable;
      if (start) begin
        src        <= pattern_source_address;
        tgt        <= pattern_target_address;
        beats_left <= pattern_total_number >> LB;
        error      <= 1'b0;
      end
      // a drop of enable mid-copy is remembered until the burst drains
      if (state == S_IDLE)                                 abort <= 1'b0;
      else if (!pattern_memcpy_enable && state != S_DONE)  abort <= 1'b1;
      if (state == S_CALC) begin
        len_m1 <= 8'(len_c - 64'd1);
        rbeat  <= '0;
        wbeat  <= '0;
      end
      if (r_fire) begin
        rbeat <= rbeat + 8'd1;
        if (m_axi_rresp != AXI_RESP_OKAY) error <= 1'b1;
      end
      if (w_fire) wbeat <= wbeat + 8'd1;
      if (b_fire) begin
        src        <= src + step_b;
        tgt        <= tgt + step_b;
        beats_left <= beats_left - 64'(len);
        if (m_axi_bresp != AXI_RESP_OKAY) error <= 1'b1;
      end
    end

  // read side prefetches one beat ahead so wdata is ready when wvalid rises
  assign buf_re    = (state == S_WR_ADDR) || (state == S_WR_DATA);
  assign buf_raddr = IW'(wbeat + 8'(w_fire));

  memcpy_burst_buf #(
    .DEPTH (BURST_MAX),
    .DW    (DATA_WIDTH),
    .AW    (IW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (r_fire),
    .waddr (IW'(rbeat)),
    .wdata (m_axi_rdata),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (m_axi_wdata)
  );

  assign m_axi_araddr         = src;
  assign m_axi_awaddr         = tgt;
  assign m_axi_arlen          = len_m1;
  assign m_axi_awlen          = len_m1;
  assign pattern_memcpy_error = error;

endmodule

// File: tb/tb_pattern_memcpy_engine.sv
// Directed bench for pattern_memcpy_engine with a small AXI slave memory model.
module tb_pattern_memcpy_engine;

  logic        clk, rst;
  logic        enable, done, error;
  logic [63:0] src_a, tgt_a, total;
  logic [63:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;

  pattern_memcpy_engine dut (
    .clk(clk), .rst(rst),
    .pattern_memcpy_enable(enable),
    .pattern_source_address(src_a), .pattern_target_address(tgt_a),
    .pattern_total_number(total),
    .pattern_memcpy_done(done), .pattern_memcpy_error(error),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- slave memory model (owned by the slave process) ----------------
  logic [63:0] mem [0:8191];
  logic [63:0] ar_log [0:63];
  logic [7:0]  arl_log [0:63];
  logic [7:0]  awl_log [0:63];
  int ar_cnt = 0, aw_cnt = 0, b_cnt = 0, w_bad = 0, cross_bad = 0;
  int err_burst = -1;   // absolute b_cnt value that gets SLVERR

  function automatic logic [63:0] pat(input int i);
    logic [31:0] u;
    u = 32'(i);
    return {32'hC0DE0000 ^ u, ~u};
  endfunction

  initial begin : slave
    logic        rd_act, wr_act, b_pend, last;
    logic [63:0] ra, wa;
    int          rleft, wcnt;
    logic [7:0]  wlen;
    logic        p_arv, p_rr, p_awv, p_wv, p_wl, p_br;
    logic [63:0] p_ara, p_awa, p_wd;
    logic [7:0]  p_arl, p_awl;
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    rd_act = 0; wr_act = 0; b_pend = 0; ra = 0; wa = 0; rleft = 0; wcnt = 0; wlen = 0;
    p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_wl = 0; p_br = 0;
    p_ara = 0; p_awa = 0; p_wd = 0; p_arl = 0; p_awl = 0;
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_act = 0; wr_act = 0; b_pend = 0;
        p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0;
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
      end else begin
        // handshakes completed at the posedge just passed
        if (rvalid && p_rr) begin
          ra = ra + 8; rleft--;
          if (rleft == 0) rd_act = 0;
        end
        if (arready && p_arv) begin
          rd_act = 1; ra = p_ara; rleft = int'(p_arl) + 1;
          ar_log[ar_cnt % 64] = p_ara; arl_log[ar_cnt % 64] = p_arl;
          if ((p_ara & 64'hFFF) + (64'(p_arl) + 1) * 8 > 64'h1000) cross_bad++;
          ar_cnt++;
        end
        if (bvalid && p_br) begin b_pend = 0; b_cnt++; end
        if (awready && p_awv) begin
          wr_act = 1; wa = p_awa; wcnt = 0; wlen = p_awl;
          awl_log[aw_cnt % 64] = p_awl;
          if ((p_awa & 64'hFFF) + (64'(p_awl) + 1) * 8 > 64'h1000) cross_bad++;
          aw_cnt++;
        end
        if (wready && p_wv) begin
          mem[int'(wa[15:3])] = p_wd;
          wa = wa + 8;
          last = (wcnt == int'(wlen));
          if (p_wl != last) w_bad++;
          wcnt++;
          if (last) begin wr_act = 0; b_pend = 1; end
        end
        // drive next cycle
        arready = !rd_act && ($urandom_range(0, 2) != 0);
        rvalid  = rd_act && ($urandom_range(0, 3) != 0);
        rdata   = mem[int'(ra[15:3])];
        rlast   = (rleft == 1);
        rresp   = 2'b00;
        awready = !wr_act && !b_pend && ($urandom_range(0, 2) != 0);
        wready  = wr_act && ($urandom_range(0, 3) != 0);
        bvalid  = b_pend && ($urandom_range(0, 1) != 0);
        bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        p_arv = arvalid; p_ara = araddr; p_arl = arlen; p_rr = rready;
        p_awv = awvalid; p_awa = awaddr; p_awl = awlen;
        p_wv = wvalid; p_wl = wlast; p_wd = wdata; p_br = bready;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] src, tgt, total;
    int          err_b;   // burst index (0-based) answered with SLVERR, -1 none
    int          bursts;
    logic [7:0]  len0;
    logic [63:0] ar0, ar1;
    logic        err;
  } vec_t;

  vec_t vt [6];

  // runs one copy to completion and checks traffic, data and status
  task automatic do_copy(input vec_t v);
    int base_ar, base_aw, base_b, wb0, cb0, bad, nb, sw, tw, i;
    base_ar = ar_cnt; base_aw = aw_cnt; base_b = b_cnt; wb0 = w_bad; cb0 = cross_bad;
    err_burst = (v.err_b < 0) ? -1 : base_b + v.err_b;
    src_a = v.src; tgt_a = v.tgt; total = v.total;
    enable = 1'b1;
    step();
    chk("error_clr_on_start", {63'd0, error}, 64'd0);
    for (i = 0; i < 4000 && !done; i++) step();
    chk("done", {63'd0, done}, 64'd1);
    chk("bresp_cnt_at_done", 64'(b_cnt - base_b), 64'(v.bursts));
    chk("ar_cnt", 64'(ar_cnt - base_ar), 64'(v.bursts));
    chk("aw_cnt", 64'(aw_cnt - base_aw), 64'(v.bursts));
    chk("arlen0", {56'd0, arl_log[base_ar % 64]}, {56'd0, v.len0});
    chk("awlen0", {56'd0, awl_log[base_aw % 64]}, {56'd0, v.len0});
    chk("araddr0", ar_log[base_ar % 64], v.ar0);
    if (v.bursts > 1) chk("araddr1", ar_log[(base_ar + 1) % 64], v.ar1);
    chk("error", {63'd0, error}, {63'd0, v.err});
    chk("wlast_pos", 64'(w_bad - wb0), 64'd0);
    chk("no_4k_cross", 64'(cross_bad - cb0), 64'd0);
    nb = int'(v.total >> 3); sw = int'(v.src >> 3); tw = int'(v.tgt >> 3);
    bad = 0;
    for (int k = 0; k < nb; k++) if (mem[tw + k] !== pat(sw + k)) bad++;
    chk("data_words_wrong", 64'(bad), 64'd0);
    chk("word_past_end", mem[tw + nb], pat(tw + nb));
    enable = 1'b0;
    step();
    chk("done_fall", {63'd0, done}, 64'd0);
    err_burst = -1;
  endtask

  initial begin : main
    vec_t v;
    int base_ar, base_aw, base_b, i;
    vt[0] = '{64'h1000, 64'h8000, 64'h100, -1, 2, 8'd15, 64'h1000, 64'h1080, 1'b0};
    vt[1] = '{64'h0FC0, 64'h2000, 64'h080, -1, 2, 8'd7,  64'h0FC0, 64'h1000, 1'b0};
    vt[2] = '{64'h3000, 64'h9000, 64'h100,  0, 2, 8'd15, 64'h3000, 64'h3080, 1'b1};
    vt[3] = '{64'h3000, 64'h9800, 64'h100, -1, 2, 8'd15, 64'h3000, 64'h3080, 1'b0};
    vt[4] = '{64'h4000, 64'h5FE0, 64'h100, -1, 3, 8'd3,  64'h4000, 64'h4020, 1'b0};
    vt[5] = '{64'h7000, 64'hA000, 64'h04F, -1, 1, 8'd8,  64'h7000, 64'h0,    1'b0};

    rst = 1'b1; enable = 1'b0; src_a = '0; tgt_a = '0; total = '0;
    repeat (3) step();
    chk("rst_valids", {58'd0, arvalid, rready, awvalid, wvalid, wlast, bready}, 64'd0);
    chk("rst_done_err", {62'd0, done, error}, 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_awaddr", awaddr, 64'd0);
    chk("rst_lens", {48'd0, arlen, awlen}, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    rst = 1'b0;
    step();

    for (int n = 0; n < 6; n++) do_copy(vt[n]);

    // byte counts below one beat: no traffic, done two cycles after the edge
    for (int z = 0; z < 2; z++) begin
      base_ar = ar_cnt; base_aw = aw_cnt;
      src_a = 64'h6000; tgt_a = 64'hB800; total = (z == 0) ? 64'h7 : 64'h0;
      enable = 1'b1;
      step();
      chk("short_done_c1", {63'd0, done}, 64'd0);
      step();
      chk("short_done_c2", {63'd0, done}, 64'd1);
      repeat (3) step();
      chk("short_done_held", {63'd0, done}, 64'd1);
      chk("short_no_ar", 64'(ar_cnt - base_ar), 64'd0);
      chk("short_no_aw", 64'(aw_cnt - base_aw), 64'd0);
      enable = 1'b0;
      step();
      chk("short_done_fall", {63'd0, done}, 64'd0);
    end

    // enable dropped while burst 1 is being read
    base_ar = ar_cnt; base_aw = aw_cnt; base_b = b_cnt;
    src_a = 64'h1000; tgt_a = 64'hB000; total = 64'h200;
    enable = 1'b1;
    for (i = 0; i < 200 && !rready; i++) step();
    chk("abort_reached_rd_data", {63'd0, rready}, 64'd1);
    enable = 1'b0;
    repeat (300) step();
    chk("abort_one_ar", 64'(ar_cnt - base_ar), 64'd1);
    chk("abort_one_aw", 64'(aw_cnt - base_aw), 64'd1);
    chk("abort_one_b", 64'(b_cnt - base_b), 64'd1);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_idle", {58'd0, arvalid, rready, awvalid, wvalid, wlast, bready}, 64'd0);
    chk("abort_burst1_data", mem[(64'hB000 >> 3) + 15], pat((64'h1000 >> 3) + 15));
    chk("abort_no_burst2", mem[(64'hB000 >> 3) + 16], pat((64'hB000 >> 3) + 16));

    // reset pulsed during write data
    src_a = 64'h1000; tgt_a = 64'hC000; total = 64'h100;
    enable = 1'b1;
    for (i = 0; i < 400 && !wvalid; i++) step();
    chk("rst_test_reached_wr", {63'd0, wvalid}, 64'd1);
    rst = 1'b1; enable = 1'b0;
    #1;
    chk("midrst_valids", {58'd0, arvalid, rready, awvalid, wvalid, wlast, bready}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    repeat (3) step();
    rst = 1'b0;
    step();
    v = vt[0];
    v.tgt = 64'hD000;
    do_copy(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
